dff_response_monitor: RTL and testbench
=======================================

// Module: dff_response_monitor
// PURPOSE
//   Self-checking observer for the rising-edge D flip-flop with synchronous reset.
//   Watches the stimulus applied to the DUT (d_in, dut_reset) and the DUT output
//   (q_in), runs a golden 1-cycle reference model, and counts mismatches over a
//   fixed sample window. Sits beside the FF in the benches and on-board self-test.
// PARAMETERS
//   CNT_W        16  width of sample/mismatch counters
//   NUM_SAMPLES  64  compared cycles per run (1..2**CNT_W-1)
//   WARMUP       2   cycles after start before comparison begins (>=1)
// PORTS
//   clk             input   1      single clock; all sampling on rising edge
//   reset           input   1      asynchronous, active-low reset
//   start           input   1      arm a run (level sampled on rising edge)
//   d_in            input   1      D value being driven into the DUT
//   dut_reset       input   1      synchronous, active-high reset driven into the DUT
//   q_in            input   1      Q output of the DUT
//   busy            output  1      high in WARMUP or CHECK
//   done            output  1      high in DONE
//   pass            output  1      done && mismatch_count==0
//   error_pulse     output  1      1-cycle strobe, cycle after a mismatching sample
//   sample_count    output  CNT_W  compared samples this run
//   mismatch_count  output  CNT_W  mismatches this run (saturating)
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; exp_q=0; busy, done, pass, error_pulse=0;
//   counters=0; warm-up counter=0.
// - Reference model: every edge, exp_q <= dut_reset ? 0 : d_in (always running,
//   also in IDLE). At any edge, exp_q equals the Q the DUT must present after it.
// - Compare: in CHECK, each edge samples (q_in !== exp_q); X/Z on q_in = mismatch.
// - FSM states IDLE, WARMUP, CHECK, DONE:
//   IDLE   : start=1 -> WARMUP; clear counters; load warm-up counter = WARMUP.
//   WARMUP : decrement each edge; at 1 -> CHECK. No compares.
//   CHECK  : per edge sample_count++; on mismatch mismatch_count++ (hold at
//            2**CNT_W-1), error_pulse=1 next cycle. Edge that makes sample_count
//            == NUM_SAMPLES -> DONE (that sample is still compared/counted).
//   DONE   : done=1, pass registered; counters held. start=1 -> WARMUP (re-arm,
//            counters cleared same edge).
// - start ignored in WARMUP and CHECK. error_pulse never high outside CHECK+1.
// - dut_reset during CHECK is legal stimulus: model follows it (exp_q=0); no abort.
// - Async reset mid-run: immediate return to IDLE, all outputs to reset values.
// - Outputs registered; done/pass rise on the edge after the last compare.
// CONFIGURATION
//   DFF_MON_FIRST_FAIL_EN defined: adds outputs first_fail_valid (1),
//     first_fail_idx (CNT_W), first_fail_exp (1), first_fail_act (1); capture the
//     sample index (0-based) and expected/actual bits of the first mismatch in a
//     run; sticky until re-arm or reset; all 0 at reset.
//   Undefined: those ports and registers absent; all other behaviour identical.
// TESTING
// 1 Correct FF, start, d_in toggling every 20 ns, NUM_SAMPLES=64 -> done after
//   WARMUP+64 cycles, mismatch_count=0, pass=1, error_pulse never asserted.
// 2 q_in stuck at 0, d_in=1 held -> every sample fails; mismatch_count=64, pass=0,
//   error_pulse high continuously from first compare+1 through last compare+1.
// 3 dut_reset=1 for 5 cycles mid-CHECK, d_in=1, correct FF -> exp_q=0 during
//   reset, mismatch_count=0; if DUT ignores reset -> mismatch_count=5.
// 4 q_in=X for the first 3 compares, then correct -> mismatch_count=3;
//   with DFF_MON_FIRST_FAIL_EN: first_fail_idx=0, exp/act recorded.
// 5 reset=0 pulsed in cycle 10 of CHECK -> outputs 0 immediately, state IDLE;
//   later start yields a clean full run with sample_count=64.
// 6 CNT_W=4, NUM_SAMPLES=15, q_in inverted -> mismatch_count saturates at 15;
//   start held high in DONE re-arms and clears counters on the next edge.

Source files
------------

// File: rtl/dff_response_monitor.sv
//------------------------------------------------------------------------------
// dff_response_monitor : golden 1-cycle model + windowed mismatch counter for a
//   sync-reset D flip-flop. Optional macro: DFF_MON_FIRST_FAIL_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dff_response_monitor #(
  parameter int CNT_W       = 16,
  parameter int NUM_SAMPLES = 64,
  parameter int WARMUP      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             d_in,
  input  logic             dut_reset,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             error_pulse,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count
`ifdef DFF_MON_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_exp,
  output logic             first_fail_act
`endif
);

  localparam int WW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_exp_q;
  logic [WW-1:0]    r_warm_cnt;
  logic             w_arm;
  logic             w_compare;
  logic             w_miss;
  logic [CNT_W-1:0] w_mis_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_WARMUP;
          w_arm        = 1'b1;
        end
      end
      S_WARMUP: begin
        if (r_warm_cnt == WW'(1)) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        // The sample taken on this edge is the last one of the window.
        if (sample_count == CNT_W'(NUM_SAMPLES - 1)) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_WARMUP;
          w_arm        = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_compare = (r_state == S_CHECK);
    // Case inequality so an X/Z on q_in is flagged rather than masked.
    w_miss    = w_compare && (q_in !== r_exp_q);

    if (w_arm)
      w_mis_next = '0;
    else if (w_miss && (mismatch_count != {CNT_W{1'b1}}))
      w_mis_next = mismatch_count + CNT_W'(1);
    else
      w_mis_next = mismatch_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_q        <= 1'b0;
      r_warm_cnt     <= '0;
      sample_count   <= '0;
      mismatch_count <= '0;
      error_pulse    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      r_exp_q <= dut_reset ? 1'b0 : d_in;

      if (w_arm) begin
        r_warm_cnt   <= WW'(WARMUP);
        sample_count <= '0;
      end else begin
        if (r_state == S_WARMUP) r_warm_cnt <= r_warm_cnt - WW'(1);
        if (w_compare)           sample_count <= sample_count + CNT_W'(1);
      end

      mismatch_count <= w_mis_next;
      error_pulse    <= w_miss;
      busy           <= (w_state_next == S_WARMUP) || (w_state_next == S_CHECK);
      done           <= (w_state_next == S_DONE);
      pass           <= (w_state_next == S_DONE) && (w_mis_next == '0);
    end
  end

`ifdef DFF_MON_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_exp   <= 1'b0;
      first_fail_act   <= 1'b0;
    end else if (w_arm) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_exp   <= 1'b0;
      first_fail_act   <= 1'b0;
    end else if (w_miss && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= sample_count;
      first_fail_exp   <= r_exp_q;
      first_fail_act   <= q_in;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_response_monitor.sv
//------------------------------------------------------------------------------
// tb_dff_response_monitor : table-driven runs with an error_pulse scoreboard,
//   plus mid-run reset and small-counter re-arm sequences.
//------------------------------------------------------------------------------
`default_nettype none

module tb_dff_response_monitor;

  localparam int N  = 64;
  localparam int W  = 2;
  localparam int N2 = 15;

  logic        clk = 1'b0;
  logic        reset, start, start2, d_in, dut_reset, q_in;
  logic        busy, done, pass, error_pulse;
  logic [15:0] sample_count, mismatch_count;
  logic        busy2, done2, pass2, error_pulse2;
  logic [3:0]  sample_count2, mismatch_count2;
`ifdef DFF_MON_FIRST_FAIL_EN
  logic        ff_valid, ff_exp, ff_act, ff_valid2, ff_exp2, ff_act2;
  logic [15:0] ff_idx;
  logic [3:0]  ff_idx2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference FFs standing in for the flip-flop under observation.
  logic ff_good = 1'b0;
  logic ff_nr   = 1'b0;
  bit   sb[$];

  int   exp_ff_idx;
  logic exp_ff_exp, exp_ff_act;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ff_good <= dut_reset ? 1'b0 : d_in;
    ff_nr   <= d_in;
  end

  dff_response_monitor #(.CNT_W(16), .NUM_SAMPLES(N), .WARMUP(W)) u_mon (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .dut_reset(dut_reset),
    .q_in(q_in), .busy(busy), .done(done), .pass(pass), .error_pulse(error_pulse),
    .sample_count(sample_count), .mismatch_count(mismatch_count)
`ifdef DFF_MON_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid), .first_fail_idx(ff_idx),
    .first_fail_exp(ff_exp), .first_fail_act(ff_act)
`endif
  );

  dff_response_monitor #(.CNT_W(4), .NUM_SAMPLES(N2), .WARMUP(W)) u_mon2 (
    .clk(clk), .reset(reset), .start(start2), .d_in(d_in), .dut_reset(dut_reset),
    .q_in(q_in), .busy(busy2), .done(done2), .pass(pass2), .error_pulse(error_pulse2),
    .sample_count(sample_count2), .mismatch_count(mismatch_count2)
`ifdef DFF_MON_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid2), .first_fail_idx(ff_idx2),
    .first_fail_exp(ff_exp2), .first_fail_act(ff_act2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // mode: 0 good FF, 1 stuck-at-0, 2 ignores dut_reset, 3 inverted, 4 wrong on first 3 compares
  // dpat: 0 toggle every 2 cycles, 1 held high, 2 random
  task automatic run(input int mode, input int dpat, input int rst_at, input int rst_len,
                     input int start_len, input int abort_at, input int exp_mm, input bit exp_pass);
    logic qv;
    bit   cmp, mm, first_seen;
    first_seen = 0;
    for (int e = 0; e <= W + N; e++) begin
      start     = (e < start_len);
      d_in      = (dpat == 0) ? 1'((e / 2) % 2) : (dpat == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      dut_reset = (e >= rst_at) && (e < rst_at + rst_len);
      cmp       = (e >= W + 1) && (e <= W + N);
      case (mode)
        0:       qv = ff_good;
        1:       qv = 1'b0;
        2:       qv = ff_nr;
        3:       qv = ~ff_good;
        default: qv = (cmp && e <= W + 3) ? ~ff_good : ff_good;
      endcase
      q_in = qv;
      mm   = cmp && (qv != ff_good);
      if (mm && !first_seen) begin
        first_seen = 1;
        exp_ff_idx = e - (W + 1);
        exp_ff_exp = ff_good;
        exp_ff_act = qv;
      end
      sb.push_back(mm);
      @(posedge clk);
      #1;
      chk("error_pulse", {31'd0, error_pulse}, {31'd0, sb.pop_front()});
      if (e == abort_at) begin
        chk("mismatch_before_abort", {16'd0, mismatch_count}, 32'(e - W));
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_error_pulse", {31'd0, error_pulse}, 0);
        chk("abort_sample_count", {16'd0, sample_count}, 0);
        chk("abort_mismatch_count", {16'd0, mismatch_count}, 0);
        sb.delete();
        start = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_abort", {31'd0, busy}, 0);
        return;
      end
    end
    start     = 1'b0;
    dut_reset = 1'b0;
    chk("done", {31'd0, done}, 1);
    chk("pass", {31'd0, pass}, {31'd0, exp_pass});
    chk("busy_end", {31'd0, busy}, 0);
    chk("sample_count", {16'd0, sample_count}, N);
    chk("mismatch_count", {16'd0, mismatch_count}, 32'(exp_mm));
  endtask

  typedef struct {
    int mode;
    int dpat;
    int rst_at;
    int rst_len;
    int start_len;
    int exp_mm;
    bit exp_pass;
  } row_t;

  row_t tbl[7];

  initial begin
    tbl[0] = '{0, 0, 0,  0, 1, 0,  1'b1};
    tbl[1] = '{1, 1, 0,  0, 1, 64, 1'b0};
    tbl[2] = '{0, 1, 12, 5, 1, 0,  1'b1};
    tbl[3] = '{2, 1, 12, 5, 1, 5,  1'b0};
    tbl[4] = '{4, 0, 0,  0, 1, 3,  1'b0};
    tbl[5] = '{3, 2, 0,  0, 6, 64, 1'b0};
    tbl[6] = '{0, 2, 0,  0, 1, 0,  1'b1};

    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    d_in = 1'b0; dut_reset = 1'b0; q_in = 1'b0;
    #2;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_pass", {31'd0, pass}, 0);
    chk("reset_error_pulse", {31'd0, error_pulse}, 0);
    chk("reset_sample_count", {16'd0, sample_count}, 0);
    chk("reset_mismatch_count", {16'd0, mismatch_count}, 0);
`ifdef DFF_MON_FIRST_FAIL_EN
    chk("reset_first_fail_valid", {31'd0, ff_valid}, 0);
`endif
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 7; r++) begin
      run(tbl[r].mode, tbl[r].dpat, tbl[r].rst_at, tbl[r].rst_len,
          tbl[r].start_len, -1, tbl[r].exp_mm, tbl[r].exp_pass);
`ifdef DFF_MON_FIRST_FAIL_EN
      if (tbl[r].mode == 4) begin
        chk("first_fail_valid", {31'd0, ff_valid}, 1);
        chk("first_fail_idx", {16'd0, ff_idx}, 32'(exp_ff_idx));
        chk("first_fail_exp", {31'd0, ff_exp}, {31'd0, exp_ff_exp});
        chk("first_fail_act", {31'd0, ff_act}, {31'd0, exp_ff_act});
      end
`endif
    end

    // Async reset in cycle 10 of CHECK, then a clean full run.
    run(1, 1, 0, 0, 1, W + 10, 0, 1'b0);
    run(0, 0, 0, 0, 1, -1, 0, 1'b1);

    // Narrow counters: inverted FF, start held high through DONE.
    start2 = 1'b1;
    for (int e = 0; e <= W + N2; e++) begin
      d_in = 1'($urandom_range(0, 1));
      q_in = ~ff_good;
      @(posedge clk);
      #1;
    end
    chk("m2_done", {31'd0, done2}, 1);
    chk("m2_pass", {31'd0, pass2}, 0);
    chk("m2_error_pulse", {31'd0, error_pulse2}, 1);
    chk("m2_sample_count", {28'd0, sample_count2}, N2);
    chk("m2_mismatch_sat", {28'd0, mismatch_count2}, 15);
    @(posedge clk);
    #1;
    chk("m2_rearm_busy", {31'd0, busy2}, 1);
    chk("m2_rearm_done", {31'd0, done2}, 0);
    chk("m2_rearm_sample_count", {28'd0, sample_count2}, 0);
    chk("m2_rearm_mismatch_count", {28'd0, mismatch_count2}, 0);
    start2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
